// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a length-prefixed little-endian byte stream into instruction memory while the core is stalled
// Optional opcode screening of each word before it is written: define IMEM_LOADER_OPCODE_CHECK_EN.
module imem_loader #(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_stall,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR} state_t;

   state_t      state, state_nxt;
   logic [15:0] len;
   logic [15:0] len_full;
   logic [31:0] word;
   logic [1:0]  lane;
   logic        done_q;
   logic        xfer;
   logic        more;
   logic        word_ok;
   logic        restart;

   assign xfer     = byte_valid && byte_ready;
   assign len_full = {byte_in, len[7:0]};
   assign more     = (32'(words_loaded) + 32'd1) < 32'(len);
   assign restart  = start && (state == IDLE || state == DONE || state == ERR);

`ifdef IMEM_LOADER_OPCODE_CHECK_EN
   // Accept only 32-bit encodings whose major opcode is one the core implements.
   always_comb begin
      word_ok = 1'b0;
      if (word[1:0] == 2'b11) begin
         case (word[6:2])
            5'b01100, 5'b00000, 5'b01000, 5'b11000, 5'b01101, 5'b00101,
            5'b11011, 5'b11001, 5'b00100, 5'b00011, 5'b11100: word_ok = 1'b1;
            default: word_ok = 1'b0;
         endcase
      end
   end
`else
   assign word_ok = 1'b1;
`endif

   always_comb begin
      state_nxt  = state;
      byte_ready = 1'b0;
      imem_we    = 1'b0;
      core_stall = 1'b1;
      case (state)
         IDLE: begin
            if (start) state_nxt = LEN0;
         end
         LEN0: begin
            byte_ready = 1'b1;
            if (byte_valid) state_nxt = LEN1;
         end
         LEN1: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               if (len_full == 16'd0)                 state_nxt = DONE;
               else if (32'(len_full) > MAX_WORDS)    state_nxt = ERR;
               else                                   state_nxt = DATA;
            end
         end
         DATA: begin
            byte_ready = 1'b1;
            if (byte_valid && lane == 2'd3) state_nxt = WRITE;
         end
         WRITE: begin
            if (!word_ok) begin
               state_nxt = ERR;
            end else begin
               imem_we   = 1'b1;
               state_nxt = more ? DATA : DONE;
            end
         end
         DONE: begin
            core_stall = 1'b0;
            if (start) state_nxt = LEN0;
         end
         ERR: begin
            core_stall = 1'b0;
            if (start) state_nxt = LEN0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         len          <= 16'd0;
         word         <= 32'd0;
         lane         <= 2'd0;
         words_loaded <= '0;
         done_q       <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= (state_nxt == DONE) && (state != DONE);
         if (restart) begin
            words_loaded <= '0;
            lane         <= 2'd0;
            len          <= 16'd0;
         end
         if (xfer) begin
            case (state)
               LEN0:    len[7:0]  <= byte_in;
               LEN1:    len[15:8] <= byte_in;
               DATA: begin
                  word[{lane, 3'b000} +: 8] <= byte_in;
                  lane                      <= lane + 2'd1;
               end
               default: ;
            endcase
         end
         if (imem_we) words_loaded <= words_loaded + (ADDR_W+1)'(1);
      end
   end

   // Address comes straight from the word count, so N = 2^ADDR_W ends at the top address without wrapping.
   assign imem_addr  = words_loaded[ADDR_W-1:0];
   assign imem_wdata = word;
   assign done       = done_q;
   assign error      = (state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - table-driven and randomized self-checking bench for imem_loader
module tb_imem_loader;

   localparam int AW = 4;
   localparam int MW = 16;
   localparam logic [6:0] LEGAL_OPS [11] = '{7'h33, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17,
                                             7'h6F, 7'h67, 7'h13, 7'h0F, 7'h73};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    byte_in = 8'd0;
   logic          byte_valid = 1'b0;
   logic          byte_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_stall;
   logic          done;
   logic          error;
   logic [AW:0]   words_loaded;

   int n_checks = 0;
   int n_pass   = 0;

   int          wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [31:0] mem [0:MW-1];
   int          done_cnt = 0;
   int          rdy_in_write = 0;

   logic [31:0] stim_words[$];
   logic [31:0] exp_wr_q[$];
   bit          exp_err_m;

   typedef struct {
      int n;
      int bub;
      bit bad;
      bit mid;
      int wl;
      bit err;
      int dn;
   } vec_t;
   vec_t vecs [10];

   imem_loader #(.ADDR_W(AW), .MAX_WORDS(MW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_stall(core_stall), .done(done), .error(error), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (imem_we) begin
         wr_addr_q.push_back(int'(imem_addr));
         wr_data_q.push_back(imem_wdata);
         mem[imem_addr] = imem_wdata;
      end
      if (done) done_cnt++;
      if (imem_we && byte_ready) rdy_in_write++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic bit word_accepted(input logic [31:0] w);
      bit hit = 1'b0;
`ifdef IMEM_LOADER_OPCODE_CHECK_EN
      foreach (LEGAL_OPS[i]) if (w[6:0] == LEGAL_OPS[i]) hit = 1'b1;
`else
      hit = 1'b1;
`endif
      return hit;
   endfunction

   // Expected write list for a load of n words drawn from stim_words.
   task automatic model(input int n);
      exp_wr_q  = {};
      exp_err_m = 1'b0;
      if (n > MW) begin
         exp_err_m = 1'b1;
         return;
      end
      for (int i = 0; i < n; i++) begin
         if (!word_accepted(stim_words[i])) begin
            exp_err_m = 1'b1;
            return;
         end
         exp_wr_q.push_back(stim_words[i]);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, output bit ok);
      ok = 1'b0;
      byte_in = b;
      byte_valid = 1'b1;
      for (int t = 0; t < 8 && !ok; t++) begin
         if (byte_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      byte_valid = 1'b0;
   endtask

   task automatic run_load(input string tag, input int n, input int bub, input bit mid,
                           input int exp_wl, input bit exp_err, input int exp_dn);
      logic [7:0] stream[$];
      int wr_base;
      int dn_base;
      int bad;
      int nw;
      bit ok;
      wr_base = wr_addr_q.size();
      dn_base = done_cnt;
      stream.push_back(n[7:0]);
      stream.push_back(n[15:8]);
      nw = (n > MW) ? 0 : n;
      for (int i = 0; i < nw; i++)
         for (int k = 0; k < 4; k++) stream.push_back(stim_words[i][8*k +: 8]);

      pulse_start();
      check({tag, ".stall_on_start"}, core_stall, 1);
      check({tag, ".err_cleared"}, error, 0);
      check({tag, ".wl_cleared"}, words_loaded, 0);

      ok = 1'b1;
      for (int i = 0; i < stream.size() && ok; i++) begin
         if (bub == 1 || (bub == 2 && $urandom_range(0, 1) == 1)) begin
            @(posedge clk); #1;
         end
         if (mid && i == 5) pulse_start();
         send_byte(stream[i], ok);
      end

      for (int t = 0; t < 12 && core_stall; t++) begin
         @(posedge clk); #1;
      end
      check({tag, ".finished"}, core_stall, 0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      check({tag, ".error"}, error, exp_err);
      check({tag, ".words_loaded"}, words_loaded, exp_wl);
      check({tag, ".done_pulses"}, done_cnt - dn_base, exp_dn);
      check({tag, ".write_count"}, wr_addr_q.size() - wr_base, exp_wr_q.size());
      bad = 0;
      for (int i = 0; i < exp_wr_q.size() && wr_base + i < wr_addr_q.size(); i++)
         if (wr_addr_q[wr_base+i] != i || wr_data_q[wr_base+i] !== exp_wr_q[i]) bad++;
      check({tag, ".write_content"}, bad, 0);
      check({tag, ".ready_low_at_end"}, byte_ready, 0);
   endtask

   initial begin
      int wr_base;
      bit ok;
      logic [31:0] w;
      int n;

      //           n       bub mid-s  wl  err done
      vecs[0] = '{1,      0, 0, 0,  1,  0,  1};
      vecs[1] = '{3,      1, 0, 0,  3,  0,  1};
      vecs[2] = '{0,      0, 0, 0,  0,  0,  1};
      vecs[3] = '{17,     0, 0, 0,  0,  1,  0};
      vecs[4] = '{1,      0, 0, 0,  1,  0,  1};
      vecs[5] = '{16,     0, 0, 0,  16, 0,  1};
      vecs[6] = '{2,      0, 0, 1,  2,  0,  1};
      vecs[7] = '{65535,  0, 0, 0,  0,  1,  0};
`ifdef IMEM_LOADER_OPCODE_CHECK_EN
      vecs[8] = '{2,      0, 1, 0,  0,  1,  0};
`else
      vecs[8] = '{2,      0, 1, 0,  2,  0,  1};
`endif
      vecs[9] = '{1,      1, 0, 0,  1,  0,  1};

      repeat (3) @(negedge clk);
      check("reset.byte_ready", byte_ready, 0);
      check("reset.imem_we", imem_we, 0);
      check("reset.imem_addr", imem_addr, 0);
      check("reset.imem_wdata", imem_wdata, 0);
      check("reset.core_stall", core_stall, 1);
      check("reset.done", done, 0);
      check("reset.error", error, 0);
      check("reset.words_loaded", words_loaded, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle.stall_held", core_stall, 1);

      for (int v = 0; v < 10; v++) begin
         stim_words = {};
         for (int i = 0; i < ((vecs[v].n > MW) ? 0 : vecs[v].n); i++)
            stim_words.push_back((vecs[v].bad && i == 0) ? 32'hFFFF_FFFF : 32'h00A0_0513 + (32'(i) << 12));
         model(vecs[v].n);
         run_load($sformatf("vec%0d", v), vecs[v].n, vecs[v].bub, vecs[v].mid,
                  vecs[v].wl, vecs[v].err, vecs[v].dn);
      end

      for (int r = 0; r < 8; r++) begin
         n = $urandom_range(0, MW + 2);
         stim_words = {};
         for (int i = 0; i < ((n > MW) ? 0 : n); i++) begin
            w = $urandom();
            if ($urandom_range(0, 3) != 0) w[6:0] = LEGAL_OPS[$urandom_range(0, 10)];
            stim_words.push_back(w);
         end
         model(n);
         run_load($sformatf("rand%0d", r), n, 2, 1'b0, exp_wr_q.size(), exp_err_m,
                  exp_err_m ? 0 : 1);
      end

      check("write_cycle_ready_low", rdy_in_write, 0);

      // Reset pulled low while the third byte of word 1 is on the bus.
      wr_base = wr_addr_q.size();
      pulse_start();
      send_byte(8'd2, ok);
      send_byte(8'd0, ok);
      send_byte(8'h13, ok);
      send_byte(8'h05, ok);
      send_byte(8'h10, ok);
      send_byte(8'h00, ok);
      send_byte(8'h93, ok);
      send_byte(8'h06, ok);
      byte_in = 8'h20;
      byte_valid = 1'b1;
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst.imem_we", imem_we, 0);
      check("midrst.core_stall", core_stall, 1);
      check("midrst.byte_ready", byte_ready, 0);
      check("midrst.words_loaded", words_loaded, 0);
      repeat (2) @(negedge clk);
      byte_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("midrst.writes", wr_addr_q.size() - wr_base, 1);
      check("midrst.mem0_kept", mem[0], 32'h0010_0513);
      check("midrst.idle_stall", core_stall, 1);
      check("midrst.idle_not_ready", byte_ready, 0);
      check("midrst.idle_no_error", error, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, width of the instruction-memory word address.
REQ-002 Parameter MAX_WORDS, default 256, largest accepted program length in words (at most 2^ADDR_W).
REQ-003 clk  input  1  single clock, all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
REQ-006 byte_in  input  8  serial program byte.
REQ-007 byte_valid  input  1  byte_in is valid.
REQ-008 byte_ready  output  1  loader accepts byte_in; a transfer occurs when byte_valid and byte_ready are both high.
REQ-009 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 imem_addr  output  ADDR_W  word address of the write.
REQ-011 imem_wdata  output  32  instruction word being written.
REQ-012 core_stall  output  1  holds fetch/PC while loading.
REQ-013 done  output  1  one-cycle pulse when the load completes.
REQ-014 error  output  1  sticky error flag, cleared by the next start.
REQ-015 words_loaded  output  ADDR_W+1  count of words written in the current load.

Function
REQ-016 The loader SHALL implement the states IDLE, LEN0, LEN1, DATA, WRITE, DONE and ERR.
REQ-017 Stream format: a 16-bit little-endian word count N (byte 0 = low byte), then N×4 bytes, each word little-endian.
REQ-018 From IDLE, DONE or ERR, start SHALL move the FSM to LEN0, clear words_loaded, clear error and assert core_stall the next cycle.
REQ-019 byte_ready SHALL be high only in LEN0, LEN1 and DATA; it SHALL be low in WRITE, IDLE, DONE and ERR.
REQ-020 LEN0 SHALL move to LEN1 on a transfer; LEN1 SHALL latch N on its transfer.
REQ-021 After LEN1: N=0 SHALL go to DONE; N>MAX_WORDS SHALL go to ERR; any other N SHALL go to DATA.
REQ-022 DATA SHALL shift transferred bytes into a 32-bit assembly register at byte lane [2-bit byte counter], and SHALL enter WRITE after the 4th byte.
REQ-023 WRITE SHALL last exactly one cycle: imem_we=1, imem_addr=words_loaded[ADDR_W-1:0], imem_wdata=the assembled word; words_loaded SHALL then increment.
REQ-024 After WRITE, the FSM SHALL return to DATA if words_loaded<N and SHALL go to DONE otherwise.
REQ-025 Minimum latency: 1 cycle per byte plus 1 WRITE cycle per word; a bubble on byte_valid SHALL stall the FSM without losing state.
REQ-026 On entry to DONE, done SHALL pulse for exactly one cycle, core_stall SHALL deassert in the same cycle, and the FSM SHALL hold in DONE.
REQ-027 In ERR, error=1, core_stall=0, imem_we=0, and no further writes SHALL occur.
REQ-028 A start pulse in LEN0, LEN1, DATA or WRITE SHALL be ignored.
REQ-029 At N=MAX_WORDS=2^ADDR_W, the last address SHALL be 2^ADDR_W-1 and the address SHALL NOT wrap.

Reset
REQ-030 While rst_n=0, the FSM SHALL be in IDLE, and all outputs, counters and registers SHALL be 0, except that core_stall SHALL be 1 so the core waits for a program.
REQ-031 Reset asserted mid-load SHALL abort immediately with no further imem_we; words already written SHALL remain in memory.

Configuration
REQ-032 Macro IMEM_LOADER_OPCODE_CHECK_EN.
- Defined: in WRITE, a word with bits[1:0]≠2'b11, or with bits[6:2] outside {01100, 00000, 01000, 11000, 01101, 00101, 11011, 11001, 00100, 00011, 11100}, SHALL suppress imem_we and go to ERR.
- Undefined: every word SHALL be written unchecked.

Verification
REQ-033 Reset, then start; stream 01 00 13 05 A0 00 -> one write, addr 0, data 0x00A00513, done pulse, core_stall low, words_loaded=1.
REQ-034 N=3 with byte_valid low every other cycle -> addresses 0, 1, 2 written in order, no dropped or duplicated bytes.
REQ-035 N=0 -> DONE after LEN1 with no imem_we; N=MAX_WORDS+1 -> error=1, no imem_we.
REQ-036 rst_n pulled low during the 3rd byte of word 1 -> imem_we stays 0, FSM in IDLE, core_stall=1.
REQ-037 With IMEM_LOADER_OPCODE_CHECK_EN defined, word 0xFFFFFFFF -> no write, error=1; without it -> written to addr 0.
REQ-038 Start during DATA -> ignored, load completes normally; start in DONE -> new load begins, error cleared.
